// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial controller between the pipeline and an 8-bit synchronous RAM.
// It serves the MEM stage (1/2/4-byte loads and stores) and IF (32-bit fetches), and
// assembles or splits little-endian words. MEM requests take priority over IF.
//
// Build option: MEMCTRL_PIPE_READ_EN
//   defined   - pipelined reads, with a new byte address every cycle (word read done in cycle 6)
//   undefined - two-cycle byte reads (word read done in cycle 9)
//   Write timing is the same in both modes.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   mem_read_req/_write_req   00 none, 01 byte, 10 half, 11 word
//   mem_addr_i, mem_wdata_i   MEM base byte address and store data
//   mem_rdata_o, mem_done     load data (zero-filled) and completion pulse
//   if_req, if_addr_i         fetch request and address
//   if_inst_o, if_done        fetched word and completion pulse
//   ram_a, ram_dout, ram_wr   RAM byte address, write byte and write enable
//   ram_din                   RAM read byte, valid the cycle after its address
//
// state | meaning
// IDLE  | sample requests; MEM write > MEM read > IF fetch
// READ  | drive byte addresses and collect returned bytes
// WRITE | drive one byte per cycle with ram_wr=1
// DONE  | one-cycle done pulse, then back to IDLE
module mem_ctrl #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mem_read_req,
    input  logic [1:0]        mem_write_req,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_done,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_inst_o,
    output logic              if_done,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base_q;
    logic [2:0]        len_q;
    logic              src_if;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] asm_q;
    logic [DATA_W-1:0] asm_nxt;
    logic [2:0]        byte_cnt;
    logic [2:0]        samp_cnt;
    logic              rd_vld;
    logic              last_samp;
    logic              if_abort;
    logic [7:0]        wr_byte;

    function automatic logic [2:0] code_len(input logic [1:0] code);
        case (code)
            2'b01:   code_len = 3'd1;
            2'b10:   code_len = 3'd2;
            2'b11:   code_len = 3'd4;
            default: code_len = 3'd0;
        endcase
    endfunction

    always_comb begin
        asm_nxt = asm_q;
        asm_nxt[{samp_cnt[1:0], 3'b000} +: 8] = ram_din;
        wr_byte   = wdata_q[{byte_cnt[1:0], 3'b000} +: 8];
        last_samp = rd_vld && (samp_cnt == len_q - 3'd1);
        // A fetch becomes stale when IF withdraws it or redirects (branch flush).
        if_abort  = src_if && (!if_req || (if_addr_i != base_q));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (mem_write_req != 2'b00)     state_nxt = WRITE;
                else if (mem_read_req != 2'b00) state_nxt = READ;
                else if (if_req)                state_nxt = READ;
            end
            WRITE: if (byte_cnt == len_q) state_nxt = DONE;
            READ: begin
                if (if_abort)       state_nxt = IDLE;
                else if (last_samp) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q      <= '0;
            len_q       <= '0;
            src_if      <= 1'b0;
            wdata_q     <= '0;
            asm_q       <= '0;
            byte_cnt    <= '0;
            samp_cnt    <= '0;
            rd_vld      <= 1'b0;
            ram_a       <= '0;
            ram_dout    <= '0;
            ram_wr      <= 1'b0;
            mem_rdata_o <= '0;
            if_inst_o   <= '0;
            mem_done    <= 1'b0;
            if_done     <= 1'b0;
        end else begin
            mem_done <= 1'b0;
            if_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (state_nxt == WRITE) begin
                        base_q   <= mem_addr_i;
                        len_q    <= code_len(mem_write_req);
                        src_if   <= 1'b0;
                        wdata_q  <= mem_wdata_i;
                        ram_a    <= mem_addr_i;
                        ram_dout <= mem_wdata_i[7:0];
                        ram_wr   <= 1'b1;
                        byte_cnt <= 3'd1;
                    end else if (state_nxt == READ) begin
                        if (mem_read_req != 2'b00) begin
                            base_q <= mem_addr_i;
                            ram_a  <= mem_addr_i;
                            len_q  <= code_len(mem_read_req);
                            src_if <= 1'b0;
                        end else begin
                            base_q <= if_addr_i;
                            ram_a  <= if_addr_i;
                            len_q  <= 3'd4;
                            src_if <= 1'b1;
                        end
                        ram_wr   <= 1'b0;
                        asm_q    <= '0;
                        byte_cnt <= 3'd1;
                        samp_cnt <= 3'd0;
                        rd_vld   <= 1'b0;
                    end
                end
                WRITE: begin
                    if (state_nxt == DONE) begin
                        ram_wr   <= 1'b0;
                        mem_done <= 1'b1;
                    end else begin
                        ram_a    <= base_q + ADDR_W'(byte_cnt);
                        ram_dout <= wr_byte;
                        byte_cnt <= byte_cnt + 3'd1;
                    end
                end
                READ: begin
                    if (!if_abort) begin
`ifdef MEMCTRL_PIPE_READ_EN
                        // Address runs one cycle ahead of the returned data.
                        rd_vld <= 1'b1;
                        if (byte_cnt < len_q) begin
                            ram_a    <= base_q + ADDR_W'(byte_cnt);
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                        if (rd_vld) begin
                            asm_q    <= asm_nxt;
                            samp_cnt <= samp_cnt + 3'd1;
                        end
`else
                        // rd_vld alternates: address cycle, then sample cycle.
                        if (!rd_vld) begin
                            rd_vld <= 1'b1;
                        end else begin
                            asm_q  <= asm_nxt;
                            rd_vld <= 1'b0;
                            if (!last_samp) begin
                                ram_a    <= base_q + ADDR_W'(samp_cnt + 3'd1);
                                samp_cnt <= samp_cnt + 3'd1;
                            end
                        end
`endif
                        if (last_samp) begin
                            if (src_if) begin
                                if_inst_o <= asm_nxt;
                                if_done   <= 1'b1;
                            end else begin
                                mem_rdata_o <= asm_nxt;
                                mem_done    <= 1'b1;
                            end
                        end
                    end
                end
                DONE:    ram_wr <= 1'b0;
                default: ram_wr <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  mem_read_req = '0;
    logic [1:0]  mem_write_req = '0;
    logic [16:0] mem_addr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic [31:0] mem_rdata_o;
    logic        mem_done;
    logic        if_req = 1'b0;
    logic [16:0] if_addr_i = '0;
    logic [31:0] if_inst_o;
    logic        if_done;
    logic [16:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_wr;
    logic [7:0]  ram_din;

    logic [7:0]  ram [0:131071];
    logic        bd_we = 1'b0;
    logic [16:0] bd_a = '0;
    logic [7:0]  bd_d = '0;

    int n_vec = 0;
    int n_bad = 0;

    mem_ctrl #(.ADDR_W(17), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_rdata_o(mem_rdata_o), .mem_done(mem_done),
        .if_req(if_req), .if_addr_i(if_addr_i),
        .if_inst_o(if_inst_o), .if_done(if_done),
        .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
    );

    always #5 clk = ~clk;

    // Synchronous byte RAM, read-first, data valid the cycle after the address.
    always @(posedge clk) begin
        if (bd_we)       ram[bd_a] <= bd_d;
        else if (ram_wr) ram[ram_a] <= ram_dout;
        ram_din <= ram[ram_a];
    end

    function automatic int rd_lat(input int n);
`ifdef MEMCTRL_PIPE_READ_EN
        return n + 2;
`else
        return 2 * n + 1;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bd_write(input logic [16:0] a, input logic [7:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_a = a; bd_d = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Issue one MEM request in cycle 0 and wait for mem_done.
    task automatic mem_xfer(input logic wr, input logic [1:0] code, input logic [16:0] a,
                            input logic [31:0] wd, output int dcyc, output int wr_cnt,
                            output logic wr_at_done);
        int cyc;
        dcyc = -1; wr_cnt = 0; wr_at_done = 1'bx; cyc = 0;
        @(posedge clk); #1;
        if (wr) mem_write_req = code; else mem_read_req = code;
        mem_addr_i = a; mem_wdata_i = wd;
        while (cyc < 30 && dcyc < 0) begin
            @(posedge clk); #1;
            cyc++;
            if (ram_wr) wr_cnt++;
            if (mem_done) begin
                dcyc = cyc;
                wr_at_done = ram_wr;
            end
        end
        mem_write_req = '0; mem_read_req = '0;
    endtask

    initial begin
        int dc, wc, cyc, c_mem, c_if, n_ifd;
        logic wd_l, seen;

        // Reset values, then backdoor preload while held in reset.
        #12;
        chk("rst_ram_a", 32'(ram_a), 32'h0);
        chk("rst_flags", {29'b0, ram_wr, mem_done, if_done}, 32'h0);
        chk("rst_rdata", mem_rdata_o, 32'h0);
        chk("rst_inst", if_inst_o, 32'h0);
        bd_write(17'h00101, 8'hEE);
        bd_write(17'h1FFFF, 8'hAB);
        bd_write(17'h00000, 8'hCD);
        bd_write(17'h00300, 8'h01);
        bd_write(17'h00301, 8'h02);
        bd_write(17'h00302, 8'h03);
        bd_write(17'h00303, 8'h04);
        bd_write(17'h00040, 8'hEF);
        bd_write(17'h00041, 8'hBE);
        bd_write(17'h00042, 8'hAD);
        bd_write(17'h00043, 8'hDE);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // 1: reset during a word store
        seen = 1'b0;
        mem_write_req = 2'b11; mem_addr_i = 17'h00100; mem_wdata_i = 32'h11223344;
        @(posedge clk); #1;
        seen |= mem_done;
        @(posedge clk); #1;
        seen |= mem_done;
        rst = 1'b0;
        #1;
        chk("t1_wr_async", {31'b0, ram_wr}, 32'h0);
        mem_write_req = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            seen |= mem_done;
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            seen |= mem_done;
        end
        chk("t1_no_done", {31'b0, seen}, 32'h0);
        chk("t1_ram101", {24'b0, ram[17'h00101]}, 32'h000000EE);

        // 2: SW 0x11223344 @0x100
        mem_xfer(1'b1, 2'b11, 17'h00100, 32'h11223344, dc, wc, wd_l);
        chk("t2_done_cyc", 32'(dc), 32'd5);
        chk("t2_wr_cycles", 32'(wc), 32'd4);
        chk("t2_wr_at_done", {31'b0, wd_l}, 32'h0);
        chk("t2_ram", {ram[17'h103], ram[17'h102], ram[17'h101], ram[17'h100]}, 32'h11223344);

        // 3: LW @0x100
        mem_xfer(1'b0, 2'b11, 17'h00100, 32'h0, dc, wc, wd_l);
        chk("t3_done_cyc", 32'(dc), 32'(rd_lat(4)));
        chk("t3_rdata", mem_rdata_o, 32'h11223344);

        // 4: LB @0x103, LH @0x1FFFF across the address wrap
        mem_xfer(1'b0, 2'b01, 17'h00103, 32'h0, dc, wc, wd_l);
        chk("t4_lb_cyc", 32'(dc), 32'(rd_lat(1)));
        chk("t4_lb_data", mem_rdata_o, 32'h00000011);
        mem_xfer(1'b0, 2'b10, 17'h1FFFF, 32'h0, dc, wc, wd_l);
        chk("t4_lh_cyc", 32'(dc), 32'(rd_lat(2)));
        chk("t4_lh_data", mem_rdata_o, 32'h0000CDAB);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_rdata_hold", mem_rdata_o, 32'h0000CDAB);

        // 5: SB and fetch in the same cycle; store wins
        @(posedge clk); #1;
        mem_write_req = 2'b01; mem_addr_i = 17'h00200; mem_wdata_i = 32'h0000005A;
        if_req = 1'b1; if_addr_i = 17'h00300;
        cyc = 0; c_mem = -1; c_if = -1;
        while (cyc < 40 && c_if < 0) begin
            @(posedge clk); #1;
            cyc++;
            if (mem_done) begin
                c_mem = cyc;
                mem_write_req = '0;
            end
            if (if_done) c_if = cyc;
        end
        if_req = 1'b0;
        chk("t5_mem_done_cyc", 32'(c_mem), 32'd2);
        chk("t5_ram200", {24'b0, ram[17'h00200]}, 32'h0000005A);
        chk("t5_if_done_cyc", 32'(c_if), 32'(3 + rd_lat(4)));
        chk("t5_inst", if_inst_o, 32'h04030201);

        // 6: fetch @0x0 redirected to 0x40 in cycle 2
        @(posedge clk); #1;
        if_req = 1'b1; if_addr_i = 17'h00000;
        cyc = 0; c_if = -1; n_ifd = 0;
        while (cyc < 40 && c_if < 0) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 2) if_addr_i = 17'h00040;
            if (cyc == 3) chk("t6_inst_hold", if_inst_o, 32'h04030201);
            if (if_done) begin
                n_ifd++;
                c_if = cyc;
            end
        end
        if_req = 1'b0;
        chk("t6_if_done_cyc", 32'(c_if), 32'(3 + rd_lat(4)));
        chk("t6_if_done_cnt", 32'(n_ifd), 32'd1);
        chk("t6_inst", if_inst_o, 32'hDEADBEEF);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
